// File: rtl/ks_audio_pkg.sv
// Shared constants for the Karplus-Strong audio path.
// Contents:
//   AUDIO_DW  - sample width used between the string generator and I2S.
//   ERR_CNT_W - width of the saturating error counters.
//   clog2()   - ceil(log2(v)), used to size pointers and level registers.
package ks_audio_pkg;

  localparam int AUDIO_DW  = 8;
  localparam int ERR_CNT_W = 8;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/req_edge_sync.sv
// Resynchronises an asynchronous request level and emits a one-cycle
// pulse on each rising edge. It is used for the I2S load request here and
// also for the SPI-driven pluck strobe.
// Ports:
//   clk_i   - system clock
//   rst_i   - synchronous reset, active high
//   d_i     - asynchronous request level
//   pulse_o - one-cycle pulse, high in the cycle after the edge reaches s1
module req_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic pulse_o
);

  logic r_s0, r_s1, r_s2;

  // During reset every stage loads the live input. A level held high
  // across reset release then looks like "already seen" and gives no pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s0 <= d_i;
      r_s1 <= d_i;
      r_s2 <= d_i;
    end else begin
      r_s0 <= d_i;
      r_s1 <= r_s0;
      r_s2 <= r_s1;
    end
  end

  assign pulse_o = r_s1 & ~r_s2;

endmodule

// File: rtl/audio_sample_fifo.sv
// Sample buffer between the Karplus-Strong generator and the I2S
// transmitter. One sample is pushed per write strobe; one is popped per
// rising edge of the asynchronous I2S load request. Overflow and underflow
// are counted in saturating counters that are read back over SPI.
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset
//   wr_en_i       - one-cycle push strobe
//   wr_data_i     - sample to push
//   rd_req_i      - async load request level, rising edge = one pop
//   clear_cnt_i   - clears both error counters
//   rd_data_o     - registered output sample
//   rd_valid_o    - one-cycle pulse when rd_data_o was updated by a pop
//   level_o       - occupancy 0..DEPTH
//   full_o        - level_o == DEPTH
//   empty_o       - level_o == 0
//   ovf_cnt_o     - dropped pushes, saturating
//   unf_cnt_o     - pops attempted while empty, saturating
module audio_sample_fifo
  import ks_audio_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_DW,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = ERR_CNT_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_req_i,
  input  logic                    clear_cnt_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    rd_valid_o,
  output logic [clog2(DEPTH):0]   level_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [CNT_WIDTH-1:0]    ovf_cnt_o,
  output logic [CNT_WIDTH-1:0]    unf_cnt_o
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic [CNT_WIDTH-1:0]  r_ovf_cnt, r_unf_cnt;

  logic w_pop, w_full, w_empty;
  logic w_push_ok, w_pop_ok, w_ovf, w_unf;

  req_edge_sync u_req_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .d_i     (rd_req_i),
    .pulse_o (w_pop)
  );

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when a pop coincides. No bypass: a pop on an empty FIFO is an
  // underflow even if a push lands in the same cycle.
  assign w_push_ok = wr_en_i & (~w_full | w_pop);
  assign w_pop_ok  = w_pop & ~w_empty;
  assign w_ovf     = wr_en_i & w_full & ~w_pop;
  assign w_unf     = w_pop & w_empty;

  // Storage is not reset; occupancy lives in r_level.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push_ok) r_mem[r_wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop_ok;
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Clear wins over a same-cycle increment; increments stop at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_cnt_i) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      if (w_ovf && !(&r_ovf_cnt)) r_ovf_cnt <= r_ovf_cnt + CNT_WIDTH'(1);
      if (w_unf && !(&r_unf_cnt)) r_unf_cnt <= r_unf_cnt + CNT_WIDTH'(1);
    end
  end

  assign rd_data_o  = r_rd_data;
  assign rd_valid_o = r_rd_valid;
  assign level_o    = r_level;
  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign ovf_cnt_o  = r_ovf_cnt;
  assign unf_cnt_o  = r_unf_cnt;

endmodule

// File: tb/tb_audio_sample_fifo.sv
module tb_audio_sample_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_req = 1'b0;
  logic       clear_cnt = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] level;
  logic       full, empty;
  logic [7:0] ovf_cnt, unf_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  audio_sample_fifo #(.DATA_WIDTH(8), .DEPTH(8), .CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_req_i(rd_req), .clear_cnt_i(clear_cnt), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .level_o(level), .full_o(full), .empty_o(empty),
    .ovf_cnt_o(ovf_cnt), .unf_cnt_o(unf_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the oldest expected sample.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rd_valid: got data 0x%0h expected no pop", rd_data);
      end else begin
        check("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit stored);
    wr_en = 1'b1;
    wr_data = d;
    if (stored) exp_q.push_back(d);
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic req_pulse();
    rd_req = 1'b1;
    tick(4);
    rd_req = 1'b0;
    tick(4);
  endtask

  initial begin
    tick(3);
    check("rst_level", 32'(level), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_ovf", 32'(ovf_cnt), 0);
    check("rst_unf", 32'(unf_cnt), 0);
    rst = 1'b0;
    tick(1);

    // In-order pops with pop latency checked on the first request.
    push(8'h11, 1); push(8'h22, 1); push(8'h33, 1);
    check("level_3", 32'(level), 3);
    rd_req = 1'b1;
    tick(1);                              // edge N samples the rise
    check("rv_at_N", 32'(rd_valid), 0);
    tick(1);
    check("rv_at_N1", 32'(rd_valid), 0);
    tick(1);
    check("rv_at_N2", 32'(rd_valid), 1);
    check("rd_data_N2", 32'(rd_data), 32'h11);
    tick(1);
    check("rv_one_cycle", 32'(rd_valid), 0);
    rd_req = 1'b0;
    tick(4);
    req_pulse(); req_pulse();
    check("level_0", 32'(level), 0);
    check("empty_after_drain", 32'(empty), 1);

    // Overflow: ninth push into a depth-8 FIFO is dropped.
    for (int i = 1; i <= 9; i++) push(8'(i), i <= 8);
    check("full_9", 32'(full), 1);
    check("level_8", 32'(level), 8);
    check("ovf_1", 32'(ovf_cnt), 1);
    for (int i = 0; i < 8; i++) req_pulse();
    check("empty_after_8", 32'(empty), 1);
    check("rd_data_08", 32'(rd_data), 32'h08);

    // Underflow: data holds, no valid (monitor flags any pulse).
    req_pulse();
    check("unf_1", 32'(unf_cnt), 1);
    check("rd_data_hold", 32'(rd_data), 32'h08);

    // Full + push + pop in the same cycle: accepted, level stays 8.
    for (int i = 1; i <= 8; i++) push(8'hB0 + 8'(i), 1);
    check("full_B", 32'(full), 1);
    rd_req = 1'b1;
    tick(2);                              // pop is high in the next cycle
    wr_en = 1'b1; wr_data = 8'hAA; exp_q.push_back(8'hAA);
    tick(1);
    wr_en = 1'b0;
    check("ovf_unchanged", 32'(ovf_cnt), 1);
    check("level_stays_8", 32'(level), 8);
    tick(1);
    rd_req = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) req_pulse();
    check("rd_data_AA_last", 32'(rd_data), 32'hAA);
    check("empty_after_AA", 32'(empty), 1);

    // Underflow saturation (1 already counted), then clear vs. increment.
    for (int i = 0; i < 259; i++) req_pulse();
    check("unf_sat", 32'(unf_cnt), 32'hFF);
    rd_req = 1'b1;
    tick(2);
    clear_cnt = 1'b1;
    tick(1);
    clear_cnt = 1'b0;
    check("unf_cleared", 32'(unf_cnt), 0);
    check("ovf_cleared", 32'(ovf_cnt), 0);
    rd_req = 1'b0;
    tick(4);

    // Request held high across reset: no pop until a fresh rising edge.
    rd_req = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_q.delete();
    push(8'hC1, 1); push(8'hC2, 1);
    tick(6);
    check("no_pop_held", 32'(level), 2);
    rd_req = 1'b0;
    tick(4);
    rd_req = 1'b1;
    tick(4);
    check("one_pop_level", 32'(level), 1);
    rd_req = 1'b0;
    tick(4);
    check("still_one", 32'(level), 1);
    check("pending_expected", exp_q.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
